rename_stage: RTL
=================

Name: rename_stage

Overview:
- Register-rename pipeline stage sitting between decode and dispatch/ROB; the direct consumer of the physical-register free list.
- Maps architectural rs1/rs2/rd to physical tags through a speculative RAT and allocates a new physical rd from the free list.
- Keeps a committed RAT driven by the commit port; returns the superseded physical register to the free list.
- On flush, restores the speculative RAT from the committed RAT.

Parameters:
TAG_W, 6, width of the opaque per-instruction tag (ROB index) passed through unchanged

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts instruction this cycle
in_rs1  in  5  arch source 1
in_rs2  in  5  arch source 2
in_rd  in  5  arch destination
in_rd_we  in  1  instruction writes rd
in_tag  in  TAG_W  passthrough tag
fl_alloc_en  out  1  dequeue strobe to free list
fl_alloc_valid  in  1  free list non-empty
fl_alloc_phys  in  6  physical register at free-list head
out_valid  out  1  renamed instruction valid
out_ready  in  1  downstream accepts
out_prs1  out  6  physical source 1
out_prs2  out  6  physical source 2
out_prd  out  6  newly allocated physical rd (0 if none)
out_old_prd  out  6  previous speculative mapping of rd (stored in ROB)
out_rd_we  out  1  registered need_alloc
out_tag  out  TAG_W  passthrough tag
commit_en  in  1  commit of an rd-writing instruction
commit_rd  in  5  committed arch rd
commit_prd  in  6  committed physical rd
free_en  out  1  return register to free list
free_phys  out  6  register returned
flush  in  1  pipeline flush / misprediction recovery

Behaviour:
- Reset: both RATs map every arch reg to P0; out_valid=0, free_en=0, free_phys=0, all out_* data regs=0. P0 is the hard-zero register and is never allocated or freed.
- need_alloc = in_rd_we && in_rd!=0.
- in_ready = !flush && (!out_valid || out_ready) && (!need_alloc || fl_alloc_valid). Combinational.
- fire = in_valid && in_ready. fl_alloc_en = fire && need_alloc; the free list dequeues on the same edge.
- On fire (1-cycle latency), the output register loads:
  - out_prs1 = rat[in_rs1], out_prs2 = rat[in_rs2]; RAT is read before this cycle's write, so an instruction never sees its own rd.
  - out_old_prd = rat[in_rd].
  - out_prd = need_alloc ? fl_alloc_phys : 0.
  - out_rd_we = need_alloc; out_tag = in_tag.
  - rat[in_rd] <= fl_alloc_phys when need_alloc.
- Reads of x0 always return 0; writes to rat[0] are suppressed.
- Output handshake: out_valid set on fire and cleared when out_ready && !fire. While out_valid && !out_ready, all out_* hold stable. Simultaneous drain and fire loads the new entry.
- Commit, registered, 1-cycle latency:
  - free_en <= commit_en && commit_rd!=0 && crat[commit_rd]!=0.
  - free_phys <= crat[commit_rd].
  - crat[commit_rd] <= commit_prd when commit_en && commit_rd!=0.
  - Otherwise free_en <= 0.
- Flush (takes priority over rename):
  - rat <= crat_next, i.e. crat including any same-cycle commit write.
  - out_valid <= 0; no fire, fl_alloc_en=0.
  - Commit is still processed normally.
  - ROB walk handles freeing of squashed prd values; this block does not return them.
- Commit and rename to the same arch reg in one cycle: independent tables, both updates occur.
- Free list empty: stall only rd-writing instructions; non-writers still proceed.
- rst mid-operation: all state returns to reset values on the next edge regardless of other inputs.

Decomposition:
- Package rename_pkg: ARCH_REGS=32, PHYS_REGS=64, areg_t (logic [4:0]), preg_t (logic [5:0]), PREG_ZERO=0.
- One natural sub-module, rename_map_table:
  - 32x preg_t array.
  - Ports: 3 async read ports, 1 write port, bulk-load input (flush copy from crat).
  - Used for the speculative RAT.
- Committed RAT stays inline (1 read, 1 write).

Test Plan:
- Reset, fl_alloc_phys=1 then 2; rename x5<-x1+x2, then x6<-x5 -> first: prs1=0, prs2=0, prd=1, old_prd=0; second: prs1=1, prd=2, old_prd=0; fl_alloc_en pulses twice.
- Instr with rd=x0, rd_we=1 -> fl_alloc_en=0, out_prd=0, out_rd_we=0, rat unchanged.
- fl_alloc_valid=0 with x7 write -> in_ready=0, no state change; a store (rd_we=0) in the next cycle is accepted with out_valid=1.
- out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> drains and accepts the next instruction in the same cycle.
- commit x5/P1, then commit x5/P3 -> first: free_en=0 (old P0); second: free_en=1, free_phys=1 one cycle later.
- Rename x5->P1, x5->P2; commit x5/P1 same cycle as flush; then rename x8<-x5 -> out_valid cleared on flush; next out_prs1=1, not 2.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types and sizes for the register-rename slice.
package rename_pkg;

    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PHYS_REGS = 64;
    localparam int unsigned AREG_W    = $clog2(ARCH_REGS);
    localparam int unsigned PREG_W    = $clog2(PHYS_REGS);

    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [PREG_W-1:0] preg_t;

    // P0 is the hard-zero physical register; never allocated or freed.
    localparam preg_t PREG_ZERO = '0;

    typedef preg_t [ARCH_REGS-1:0] map_t;

    typedef struct packed {
        preg_t prs1;
        preg_t prs2;
        preg_t prd;
        preg_t old_prd;
        logic  rd_we;
    } rename_out_t;

endpackage

// File: rtl/rename_map_table.sv
// Arch-to-phys map: three async read ports, one write port, bulk load for flush recovery.
module rename_map_table
    import rename_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  areg_t rd_addr0,
    input  areg_t rd_addr1,
    input  areg_t rd_addr2,
    output preg_t rd_data0_c,
    output preg_t rd_data1_c,
    output preg_t rd_data2_c,
    input  logic  we,
    input  areg_t wr_addr,
    input  preg_t wr_data,
    input  logic  load_en,
    input  map_t  load_map
);

    map_t map_q;
    map_t map_d;

    // Bulk load wins over a single write; entry 0 is pinned to P0.
    always_comb begin
        map_d = map_q;
        if (load_en) begin
            map_d = load_map;
        end else if (we && (wr_addr != '0)) begin
            map_d[wr_addr] = wr_data;
        end
        map_d[0] = PREG_ZERO;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            map_q <= '0;
        end else begin
            map_q <= map_d;
        end
    end

    assign rd_data0_c = (rd_addr0 == '0) ? PREG_ZERO : map_q[rd_addr0];
    assign rd_data1_c = (rd_addr1 == '0) ? PREG_ZERO : map_q[rd_addr1];
    assign rd_data2_c = (rd_addr2 == '0) ? PREG_ZERO : map_q[rd_addr2];

endmodule

// File: rtl/rename_stage.sv
// Rename stage: speculative RAT lookup + free-list allocation, committed RAT with
// superseded-register release, and flush recovery of the speculative RAT.
module rename_stage
    import rename_pkg::*;
#(
    parameter int unsigned TAG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AREG_W-1:0] in_rs1,
    input  logic [AREG_W-1:0] in_rs2,
    input  logic [AREG_W-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              fl_alloc_en,
    input  logic              fl_alloc_valid,
    input  logic [PREG_W-1:0] fl_alloc_phys,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PREG_W-1:0] out_prs1,
    output logic [PREG_W-1:0] out_prs2,
    output logic [PREG_W-1:0] out_prd,
    output logic [PREG_W-1:0] out_old_prd,
    output logic              out_rd_we,
    output logic [TAG_W-1:0]  out_tag,
    input  logic              commit_en,
    input  logic [AREG_W-1:0] commit_rd,
    input  logic [PREG_W-1:0] commit_prd,
    output logic              free_en,
    output logic [PREG_W-1:0] free_phys,
    input  logic              flush
);

    logic        need_alloc_c;
    logic        fire_c;
    preg_t       rs1_map_c;
    preg_t       rs2_map_c;
    preg_t       rd_map_c;

    map_t        crat_q,      crat_d;
    rename_out_t out_q,       out_d;
    logic        out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic        free_en_q,   free_en_d;
    preg_t       free_phys_q, free_phys_d;

    assign need_alloc_c = in_rd_we && (in_rd != '0);
    assign in_ready     = !flush && (!out_valid_q || out_ready) && (!need_alloc_c || fl_alloc_valid);
    assign fire_c       = in_valid && in_ready;
    assign fl_alloc_en  = fire_c && need_alloc_c;

    rename_map_table u_spec_rat (
        .clk        (clk),
        .rst        (rst),
        .rd_addr0   (in_rs1),
        .rd_addr1   (in_rs2),
        .rd_addr2   (in_rd),
        .rd_data0_c (rs1_map_c),
        .rd_data1_c (rs2_map_c),
        .rd_data2_c (rd_map_c),
        .we         (fl_alloc_en),
        .wr_addr    (in_rd),
        .wr_data    (fl_alloc_phys),
        .load_en    (flush),
        .load_map   (crat_d)
    );

    // Committed RAT; the superseded mapping is released unless it is P0.
    always_comb begin
        crat_d      = crat_q;
        free_en_d   = 1'b0;
        free_phys_d = free_phys_q;
        if (commit_en) begin
            free_phys_d = crat_q[commit_rd];
            if (commit_rd != '0) begin
                free_en_d         = (crat_q[commit_rd] != PREG_ZERO);
                crat_d[commit_rd] = commit_prd;
            end
        end
        crat_d[0] = PREG_ZERO;
    end

    // Output register: flush squashes, fire loads, drain without fire empties.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_tag_d   = out_tag_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire_c) begin
            out_valid_d   = 1'b1;
            out_d.prs1    = rs1_map_c;
            out_d.prs2    = rs2_map_c;
            out_d.old_prd = rd_map_c;
            out_d.prd     = need_alloc_c ? fl_alloc_phys : PREG_ZERO;
            out_d.rd_we   = need_alloc_c;
            out_tag_d     = in_tag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crat_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            free_en_q   <= 1'b0;
            free_phys_q <= '0;
        end else begin
            crat_q      <= crat_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            free_en_q   <= free_en_d;
            free_phys_q <= free_phys_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_prs1    = out_q.prs1;
    assign out_prs2    = out_q.prs2;
    assign out_prd     = out_q.prd;
    assign out_old_prd = out_q.old_prd;
    assign out_rd_we   = out_q.rd_we;
    assign out_tag     = out_tag_q;
    assign free_en     = free_en_q;
    assign free_phys   = free_phys_q;

endmodule
